ram_port_arbiter: RTL and testbench



---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_port_arbiter_if.sv | 31 +++
 rtl/rr_arbiter2.sv | 45 ++++
 rtl/ram_port_arbiter.sv | 91 +++++++++
 tb/tb_ram_port_arbiter.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared widths and requester-id type for the two-port RAM arbiter.
// The id is a single bit, so a one-hot grant maps directly onto it.
package ram_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int RD_LAT = 1;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    function automatic logic [1:0] id_to_onehot(input req_id_t id);
        return (id == REQ1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of client request/response signals and RAM command/return signals.
// slave = arbiter side, master = client and RAM side.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = ram_arb_pkg::ADDR_W,
    parameter int DATA_W = ram_arb_pkg::DATA_W
);
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, ram_q,
        output gnt, rvalid, rdata, ram_addr, ram_data, ram_wren
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, ram_q,
        input  gnt, rvalid, rdata, ram_addr, ram_data, ram_wren
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant plus a registered
// priority pointer that flips to the other requester after every grant.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_t ptr_reg;
    req_id_t ptr_next;

    // Grant is masked while reset is high so no access leaks through.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = id_to_onehot(ptr_reg);
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (gnt[0]) begin
            ptr_next = REQ1;
        end else if (gnt[1]) begin
            ptr_next = REQ0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= REQ0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous single-port RAM between two clients: registers the
// granted command and tags each read so its return goes to the right client.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ram_arb_pkg::ADDR_W,
    parameter int DATA_W = ram_arb_pkg::DATA_W,
    parameter int RD_LAT = ram_arb_pkg::RD_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_port_arbiter_if.slave     bus
);

    logic [1:0]        gnt;
    req_id_t           gnt_id;
    logic              rd_issue;

    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_data_reg;
    logic              ram_wren_reg;
    logic [1:0]        rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;

    // Stage gi holds a read issued gi+1 edges ago; the last stage lines up
    // with ram_q carrying that read's data.
    logic    tag_vld_reg [RD_LAT+1];
    req_id_t tag_id_reg  [RD_LAT+1];

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (bus.req),
        .gnt   (gnt)
    );

    assign gnt_id   = gnt[1] ? REQ1 : REQ0;
    assign rd_issue = (|gnt) && !bus.we[gnt_id];

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_reg <= '0;
            ram_data_reg <= '0;
            ram_wren_reg <= 1'b0;
        end else if (|gnt) begin
            ram_addr_reg <= (gnt_id == REQ1) ? bus.addr1  : bus.addr0;
            ram_data_reg <= (gnt_id == REQ1) ? bus.wdata1 : bus.wdata0;
            ram_wren_reg <= bus.we[gnt_id];
        end else begin
            ram_wren_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi <= RD_LAT; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (reset) begin
                    tag_vld_reg[gi] <= 1'b0;
                    tag_id_reg[gi]  <= REQ0;
                end else if (gi == 0) begin
                    tag_vld_reg[gi] <= rd_issue;
                    tag_id_reg[gi]  <= gnt_id;
                end else begin
                    tag_vld_reg[gi] <= tag_vld_reg[gi-1];
                    tag_id_reg[gi]  <= tag_id_reg[gi-1];
                end
            end
        end
    endgenerate

    // rdata keeps its last value between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_reg <= 2'b00;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= tag_vld_reg[RD_LAT] ? id_to_onehot(tag_id_reg[RD_LAT]) : 2'b00;
            if (tag_vld_reg[RD_LAT]) begin
                rdata_reg <= bus.ram_q;
            end
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rvalid   = rvalid_reg;
    assign bus.rdata    = rdata_reg;
    assign bus.ram_addr = ram_addr_reg;
    assign bus.ram_data = ram_data_reg;
    assign bus.ram_wren = ram_wren_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural 32x4 RAM, a shadow memory and a
// queue of expected read returns checked against rvalid/rdata every cycle.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    logic clk;
    logic reset;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram_mem [32];
    logic [DATA_W-1:0] shadow  [32];

    always_ff @(posedge clk) begin
        if (bus.ram_wren) begin
            ram_mem[bus.ram_addr] <= bus.ram_data;
        end
        bus.ram_q <= ram_mem[bus.ram_addr];
    end

    typedef struct {
        logic [1:0]        rv;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end else begin
            $display("ok   %s cyc=%0d val=%0h", tag, cyc, got);
        end
    endtask

    // One clock cycle: drive, check at negedge, update model, advance to posedge+1.
    task automatic tick(input logic rst, input logic [1:0] r, input logic [1:0] w,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [3:0] d0, input logic [3:0] d1,
                        input logic [1:0] eg);
        exp_t e;
        reset      = rst;
        bus.req    = r;
        bus.we     = w;
        bus.addr0  = a0;
        bus.addr1  = a1;
        bus.wdata0 = d0;
        bus.wdata1 = d1;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_eq("rvalid", 32'(bus.rvalid), 32'(e.rv));
            check_eq("rdata", 32'(bus.rdata), 32'(e.data));
        end else begin
            check_eq("rvalid_idle", 32'(bus.rvalid), 32'd0);
        end
        check_eq("gnt", 32'(bus.gnt), 32'(eg));
        if (eg == 2'b01) begin
            if (w[0]) shadow[a0] = d0;
            else sb.push_back('{rv: 2'b01, data: shadow[a0], due: cyc + 3});
        end else if (eg == 2'b10) begin
            if (w[1]) shadow[a1] = d1;
            else sb.push_back('{rv: 2'b10, data: shadow[a1], due: cyc + 3});
        end
        if (rst) sb.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 2'b00, 5'h0, 5'h0, 4'h0, 4'h0, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
        reset = 1'b1;
        bus.req = 2'b00; bus.we = 2'b00;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        @(posedge clk);
        #1;

        // Reset with both requesting: grant must stay masked.
        tick(1'b1, 2'b11, 2'b00, 5'h01, 5'h02, 4'h0, 4'h0, 2'b00);
        tick(1'b1, 2'b11, 2'b00, 5'h01, 5'h02, 4'h0, 4'h0, 2'b00);
        check_eq("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check_eq("rst_ram_wren", 32'(bus.ram_wren), 32'd0);
        check_eq("rst_rdata", 32'(bus.rdata), 32'd0);

        // Single write from requester 0, command appears one edge later.
        tick(1'b0, 2'b01, 2'b01, 5'h06, 5'h00, 4'hA, 4'h0, 2'b01);
        check_eq("cmd_ram_addr", 32'(bus.ram_addr), 32'h06);
        check_eq("cmd_ram_data", 32'(bus.ram_data), 32'hA);
        check_eq("cmd_ram_wren", 32'(bus.ram_wren), 32'd1);
        idle(1);
        check_eq("hold_ram_wren", 32'(bus.ram_wren), 32'd0);
        check_eq("hold_ram_addr", 32'(bus.ram_addr), 32'h06);
        tick(1'b0, 2'b10, 2'b10, 5'h00, 5'h07, 4'h0, 4'h5, 2'b10);
        idle(3);

        // Contention after reset: alternating grants starting at requester 0.
        tick(1'b1, 2'b00, 2'b00, 5'h0, 5'h0, 4'h0, 4'h0, 2'b00);
        tick(1'b0, 2'b11, 2'b00, 5'h06, 5'h07, 4'h0, 4'h0, 2'b01);
        tick(1'b0, 2'b11, 2'b00, 5'h06, 5'h07, 4'h0, 4'h0, 2'b10);
        tick(1'b0, 2'b11, 2'b00, 5'h06, 5'h07, 4'h0, 4'h0, 2'b01);
        tick(1'b0, 2'b11, 2'b00, 5'h06, 5'h07, 4'h0, 4'h0, 2'b10);
        idle(4);

        // Write by requester 1, read back by requester 0.
        tick(1'b0, 2'b10, 2'b10, 5'h00, 5'h16, 4'h0, 4'h6, 2'b10);
        tick(1'b0, 2'b01, 2'b00, 5'h16, 5'h00, 4'h0, 4'h0, 2'b01);
        idle(4);

        // Reset lands one cycle before a read return: no stale pulse.
        tick(1'b0, 2'b01, 2'b00, 5'h16, 5'h00, 4'h0, 4'h0, 2'b01);
        idle(1);
        tick(1'b1, 2'b00, 2'b00, 5'h0, 5'h0, 4'h0, 4'h0, 2'b00);
        check_eq("mid_rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check_eq("mid_rst_ram_data", 32'(bus.ram_data), 32'd0);
        check_eq("mid_rst_ram_wren", 32'(bus.ram_wren), 32'd0);
        check_eq("mid_rst_rdata", 32'(bus.rdata), 32'd0);
        idle(2);
        tick(1'b0, 2'b11, 2'b00, 5'h07, 5'h06, 4'h0, 4'h0, 2'b01);
        tick(1'b0, 2'b10, 2'b00, 5'h07, 5'h06, 4'h0, 4'h0, 2'b10);
        idle(4);

        // Top address word, then an untouched word at address 0.
        tick(1'b0, 2'b01, 2'b01, 5'h1F, 5'h00, 4'hF, 4'h0, 2'b01);
        tick(1'b0, 2'b01, 2'b00, 5'h1F, 5'h00, 4'h0, 4'h0, 2'b01);
        tick(1'b0, 2'b10, 2'b00, 5'h00, 5'h00, 4'h0, 4'h0, 2'b10);
        idle(4);

        // Lone requester granted every cycle with no bubble.
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 2'b01, 2'b00, 5'(i + 5), 5'h00, 4'h0, 4'h0, 2'b01);
        end
        idle(4);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
